bus_source_arbiter: RTL and testbench

//  Round-robin arbiter that shares the processor's 16-bit, 8-source datapath bus

---
 rtl/bus_source_arbiter.sv | 137 +++++++++++++
 tb/tb_bus_source_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bus_source_arbiter.sv
// rtl/bus_source_arbiter.sv - round-robin 8-source bus arbiter with per-grant hold limit
module bus_source_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Req,
  output logic [7:0] Gnt,
  output logic [2:0] Sel,
  output logic       BusValid,
  output logic       Preempt
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             bus_valid_q, bus_valid_d;
  logic             preempt_q, preempt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [7:0] owner_oh;
  logic [7:0] others;
  logic [2:0] win_any;
  logic [2:0] win_oth;

  // First requester at or after the rotating pointer, wrapping mod 8
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Candidate winners: any requester, and any requester other than the current owner
  always_comb begin
    owner_oh = 8'b1 << sel_q;
    others   = Req & ~owner_oh;
    win_any  = pick(Req, ptr_q);
    win_oth  = pick(others, ptr_q);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    bus_valid_d = bus_valid_q;
    preempt_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (Req != 8'h00) begin
          state_d     = BUSY;
          gnt_d       = 8'b1 << win_any;
          sel_d       = win_any;
          bus_valid_d = 1'b1;
          ptr_d       = win_any + 3'd1;
          hold_cnt_d  = HOLD_ONE;
        end
      end
      BUSY: begin
        if (Req[sel_q] && hold_cnt_q < HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else if (!Req[sel_q]) begin
          // Owner released; hand straight over without a dead cycle if anyone waits
          if (Req != 8'h00) begin
            gnt_d      = 8'b1 << win_any;
            sel_d      = win_any;
            ptr_d      = win_any + 3'd1;
            hold_cnt_d = HOLD_ONE;
          end else begin
            state_d     = IDLE;
            gnt_d       = 8'h00;
            sel_d       = 3'd0;
            bus_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (others != 8'h00) begin
          // Hold limit reached with contention: forced handover, owner excluded
          gnt_d      = 8'b1 << win_oth;
          sel_d      = win_oth;
          ptr_d      = win_oth + 3'd1;
          hold_cnt_d = HOLD_ONE;
          preempt_d  = 1'b1;
        end else begin
          // Hold limit reached but uncontended: owner keeps the bus, window restarts
          hold_cnt_d = HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset dominates
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      gnt_q       <= 8'h00;
      sel_q       <= 3'd0;
      bus_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      bus_valid_q <= bus_valid_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign Gnt      = gnt_q;
  assign Sel      = sel_q;
  assign BusValid = bus_valid_q;
  assign Preempt  = preempt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb/tb_bus_source_arbiter.sv - self-checking bench for bus_source_arbiter
module tb_bus_source_arbiter;

  localparam int MAX_HOLD = 4;

  logic       Clk;
  logic       Reset;
  logic [7:0] Req;
  logic [7:0] Gnt;
  logic [2:0] Sel;
  logic       BusValid;
  logic       Preempt;

  int n_cmp;
  int n_bad;

  bus_source_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .Gnt(Gnt), .Sel(Sel), .BusValid(BusValid), .Preempt(Preempt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t tbl [16];

  // reference model state
  int m_owner;
  int m_hold;
  int m_ptr;
  bit m_pre;

  task automatic cyc(input logic rst, input logic [7:0] r);
    @(negedge Clk);
    Reset = rst;
    Req   = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es,
                       input logic ev, input logic ep);
    n_cmp++;
    if (Gnt !== eg || Sel !== es || BusValid !== ev || Preempt !== ep) begin
      n_bad++;
      $display("FAIL %s: got Gnt=%h Sel=%0d BusValid=%b Preempt=%b, expected Gnt=%h Sel=%0d BusValid=%b Preempt=%b",
               name, Gnt, Sel, BusValid, Preempt, eg, es, ev, ep);
    end
  endtask

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_owner = w;
    m_hold  = 1;
    m_ptr   = (w + 1) % 8;
  endtask

  task automatic model_step(input logic rst, input logic [7:0] r);
    logic [7:0] oth;
    m_pre = 1'b0;
    if (rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      if (r != 0) m_grant(first_from(r, m_ptr));
    end else if (r[m_owner] && m_hold < MAX_HOLD) begin
      m_hold++;
    end else if (!r[m_owner]) begin
      if (r != 0) m_grant(first_from(r, m_ptr));
      else begin m_owner = -1; m_hold = 0; end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (oth != 0) begin
        m_grant(first_from(oth, m_ptr));
        m_pre = 1'b1;
      end else m_hold = 1;
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       rs;
    logic [7:0] eg;
    int         own;
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    Req   = 8'h00;

    // reset, single-source transfer, release-with-handover, reset mid-grant
    tbl[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h28, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h11, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].req);
      check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].pre);
    end

    // all sources requesting: 4-cycle turns 0..7 and wrap back to 0
    cyc(1'b1, 8'hFF);
    cyc(1'b1, 8'hFF);
    for (int n = 1; n <= 36; n++) begin
      cyc(1'b0, 8'hFF);
      own = ((n - 1) / MAX_HOLD) % 8;
      eg  = 8'h01 << own;
      check($sformatf("rotate[%0d]", n), eg, 3'(own), 1'b1,
            (n > 1) && ((n - 1) % MAX_HOLD == 0));
    end

    // lone requester keeps the bus past the hold limit without preempt
    cyc(1'b1, 8'h00);
    for (int n = 1; n <= 12; n++) begin
      cyc(1'b0, 8'h40);
      check($sformatf("solo[%0d]", n), 8'h40, 3'd6, 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00);
    check("solo_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // random traffic against the reference model
    cyc(1'b1, 8'h00);
    model_step(1'b1, 8'h00);
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 4) == 0) r = 8'h00;
      else r = 8'($urandom) & 8'($urandom | $urandom);
      if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
      cyc(rs, r);
      model_step(rs, r);
      if (m_owner < 0) check($sformatf("rand[%0d]", n), 8'h00, 3'd0, 1'b0, 1'b0);
      else check($sformatf("rand[%0d]", n), 8'h01 << m_owner, 3'(m_owner), 1'b1, m_pre);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
